board_row_arbiter: RTL and testbench
====================================

BOARD_ROW_ARBITER -- requirements
Module: board_row_arbiter

Interface
REQ-001 SHALL have parameters ROWS=20 (legal board rows) and DISP_STREAK=4 (max consecutive display grants while CPU waits).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cpu_get  input  1  MEM-stage getRow request, level, held until serviced.
REQ-005 cpu_send  input  1  MEM-stage sendRow request, level, held until serviced.
REQ-006 cpu_row  input  5  CPU row index.
REQ-007 cpu_wdata  input  32  CPU row write data.
REQ-008 cpu_stall  output  1  freeze PC and pipeline registers this cycle.
REQ-009 cpu_rvalid / cpu_rdata  output  1 / 32  getRow result valid and data.
REQ-010 disp_req / disp_row  input  1 / 5  display scanner read request (level) and row index.
REQ-011 disp_rvalid / disp_rdata  output  1 / 32  display read result valid and data.
REQ-012 mem_en, mem_we, mem_addr[4:0], mem_wdata[31:0]  output  board RAM port; mem_rdata[31:0] input, valid exactly 1 cycle after mem_en with mem_we=0.
REQ-013 protocol_err  output  1  one-cycle pulse on illegal CPU request.

Function
REQ-014 SHALL implement FSM {IDLE, CPU_RD, DISP_RD}; arbitration and grants occur only in IDLE.
REQ-015 In IDLE, grant SHALL be combinational and drive mem_en=1, mem_addr=granted row in the same cycle.
REQ-016 Read grant: IDLE -> CPU_RD or DISP_RD; next cycle the matching rvalid=1 with rdata=mem_rdata, then -> IDLE (no grant issued in RD states).
REQ-017 CPU send grant: mem_we=1, mem_wdata=cpu_wdata in the grant cycle; FSM stays IDLE; write completes in 1 cycle.
REQ-018 cpu_stall SHALL equal (cpu_get|cpu_send) & ~(send granted this cycle) & ~(cpu_rvalid this cycle).
REQ-019 Priority: display over CPU, except when streak counter == DISP_STREAK, then CPU wins.
REQ-020 Streak counter SHALL increment on each display grant while a CPU request is pending, saturate at DISP_STREAK, and clear on a CPU grant or any cycle with no CPU request.
REQ-021 cpu_get & cpu_send together: treated as send; protocol_err pulses in the grant cycle.
REQ-022 Row index >= ROWS: no RAM access (mem_en=0), writes dropped, reads return rvalid with rdata=0 on the normal cycle; FSM timing unchanged.
REQ-023 Display read throughput SHALL be one row per 2 cycles when uncontended.
REQ-024 mem_en, mem_we SHALL be 0 in CPU_RD and DISP_RD.

Reset
REQ-025 On rst low: FSM=IDLE, streak=0; cpu_stall, cpu_rvalid, disp_rvalid, mem_en, mem_we, protocol_err = 0; all data/address outputs = 0.
REQ-026 Reset mid-read SHALL discard the in-flight read; no rvalid after release.
REQ-027 First grant no earlier than the first rising edge after rst deasserts.

Structure
REQ-028 Shared package vetris_pkg SHALL hold ROWS, ROW_IDX_W=5, ROW_DATA_W=32, and the FSM state enum.
REQ-029 Streak counter SHALL be a sub-module arb_streak_ctr (inc, clr, sat output); remainder in one module.

Verification
REQ-030 Uncontended get row 3, RAM[3]=0x000003FF -> mem_en cycle 0, cpu_rvalid=1 and cpu_rdata=0x000003FF cycle 1, cpu_stall=1 only cycle 0.
REQ-031 Send row 19 data 0x0000_0201 -> mem_we=1, addr=19 same cycle, cpu_stall=0; later get row 19 returns 0x0000_0201.
REQ-032 disp_req held continuously plus cpu_get row 5 -> exactly 4 display reads, then CPU read, cpu_stall high throughout wait.
REQ-033 Get row 25 -> mem_en=0, cpu_rvalid next cycle, cpu_rdata=0; send row 20 -> RAM unchanged.
REQ-034 cpu_get=cpu_send=1 row 7 -> write performed, protocol_err one-cycle pulse.
REQ-035 rst low during CPU_RD -> all outputs 0, no cpu_rvalid after release, next request serviced normally.

Source files
------------

// File: rtl/board_row_arbiter_pkg.sv
// vetris_pkg: shared board geometry and row-arbiter FSM state encoding.
package vetris_pkg;
  localparam int ROWS = 20;
  localparam int DISP_STREAK = 4;
  localparam int ROW_IDX_W = 5;
  localparam int ROW_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, CPU_RD, DISP_RD} state_t;
endpackage

// File: rtl/board_row_arbiter_if.sv
// board_row_arbiter_if: CPU, display-scanner and board-RAM signals of the row arbiter.
interface board_row_arbiter_if;
  import vetris_pkg::*;
  logic cpu_get;
  logic cpu_send;
  logic [ROW_IDX_W-1:0] cpu_row;
  logic [ROW_DATA_W-1:0] cpu_wdata;
  logic cpu_stall;
  logic cpu_rvalid;
  logic [ROW_DATA_W-1:0] cpu_rdata;
  logic disp_req;
  logic [ROW_IDX_W-1:0] disp_row;
  logic disp_rvalid;
  logic [ROW_DATA_W-1:0] disp_rdata;
  logic mem_en;
  logic mem_we;
  logic [ROW_IDX_W-1:0] mem_addr;
  logic [ROW_DATA_W-1:0] mem_wdata;
  logic [ROW_DATA_W-1:0] mem_rdata;
  logic protocol_err;
  modport master (
    output cpu_get, cpu_send, cpu_row, cpu_wdata, disp_req, disp_row, mem_rdata,
    input cpu_stall, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata,
    input mem_en, mem_we, mem_addr, mem_wdata, protocol_err
  );
  modport slave (
    input cpu_get, cpu_send, cpu_row, cpu_wdata, disp_req, disp_row, mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, protocol_err
  );
endinterface

// File: rtl/board_row_arbiter_streak_ctr.sv
// arb_streak_ctr: saturating count of display grants taken while the CPU waits.
module arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] r_cnt;
  assign sat = r_cnt == W'(MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= clr ? '0 : (inc && !sat) ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/board_row_arbiter.sv
// board_row_arbiter: shares the single-port board RAM between the CPU MEM stage and the display scanner.
module board_row_arbiter #(
  parameter int ROWS = vetris_pkg::ROWS,
  parameter int DISP_STREAK = vetris_pkg::DISP_STREAK
) (
  input logic clk,
  input logic rst,
  board_row_arbiter_if.slave bus
);
  import vetris_pkg::*;
  state_t r_state;
  logic r_oor;
  logic w_idle, w_cpu_req, w_sat, w_disp_win, w_cpu_win, w_cpu_wr, w_row_ok;
  logic [ROW_IDX_W-1:0] w_row;
  // Grants are combinational in IDLE; gating with rst keeps the RAM port quiet during reset.
  assign w_idle = rst && r_state == IDLE;
  assign w_cpu_req = bus.cpu_get | bus.cpu_send;
  assign w_disp_win = w_idle & bus.disp_req & ~(w_cpu_req & w_sat);
  assign w_cpu_win = w_idle & w_cpu_req & ~w_disp_win;
  assign w_cpu_wr = w_cpu_win & bus.cpu_send;
  assign w_row = w_disp_win ? bus.disp_row : bus.cpu_row;
  assign w_row_ok = w_row < ROW_IDX_W'(ROWS);
  assign bus.mem_en = (w_disp_win | w_cpu_win) & w_row_ok;
  assign bus.mem_we = w_cpu_wr & w_row_ok;
  assign bus.mem_addr = bus.mem_en ? w_row : '0;
  assign bus.mem_wdata = bus.mem_we ? bus.cpu_wdata : '0;
  assign bus.protocol_err = w_cpu_win & bus.cpu_get & bus.cpu_send;
  assign bus.cpu_rvalid = r_state == CPU_RD;
  assign bus.disp_rvalid = r_state == DISP_RD;
  // Out-of-range reads complete on time but return zero instead of stale RAM output.
  assign bus.cpu_rdata = (bus.cpu_rvalid && !r_oor) ? bus.mem_rdata : '0;
  assign bus.disp_rdata = (bus.disp_rvalid && !r_oor) ? bus.mem_rdata : '0;
  assign bus.cpu_stall = rst & w_cpu_req & ~w_cpu_wr & ~bus.cpu_rvalid;
  arb_streak_ctr #(.MAX(DISP_STREAK)) u_streak (
    .clk(clk),
    .rst(rst),
    .inc(w_disp_win & w_cpu_req),
    .clr(w_cpu_win | ~w_cpu_req),
    .sat(w_sat)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_oor <= 1'b0;
    end else begin
      r_state <= w_disp_win ? DISP_RD : (w_cpu_win && !bus.cpu_send) ? CPU_RD : IDLE;
      r_oor <= ~w_row_ok;
    end
endmodule

// File: tb/tb_board_row_arbiter.sv
// tb_board_row_arbiter: directed stimulus with a read-data scoreboard against a behavioural board RAM.
module tb_board_row_arbiter;
  logic clk;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ram [0:31];
  logic [31:0] model [0:31];
  logic [31:0] cpu_q [$];
  logic [31:0] disp_q [$];
  logic [31:0] exp_c, exp_d;
  board_row_arbiter_if bus();
  board_row_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 32'h0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.cpu_rvalid) begin
      exp_c = cpu_q.size() != 0 ? cpu_q.pop_front() : 32'hBAD0_0000;
      chk("cpu_rdata", bus.cpu_rdata, exp_c);
    end
    if (bus.disp_rvalid) begin
      exp_d = disp_q.size() != 0 ? disp_q.pop_front() : 32'hBAD0_0000;
      chk("disp_rdata", bus.disp_rdata, exp_d);
    end
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic get_row(input logic [4:0] row);
    bus.cpu_get = 1'b1;
    bus.cpu_row = row;
    cpu_q.push_back(row < 5'd20 ? model[row] : 32'h0);
    @(negedge clk);
    chk("get_en", bus.mem_en, row < 5'd20);
    chk("get_stall0", bus.cpu_stall, 1);
    if (row < 5'd20) chk("get_addr", bus.mem_addr, row);
    cyc();
    @(negedge clk);
    chk("get_stall1", bus.cpu_stall, 0);
    chk("rd_en_idle", bus.mem_en, 0);
    cyc();
    bus.cpu_get = 1'b0;
  endtask
  task automatic send_row(input logic [4:0] row, input logic [31:0] data, input logic both);
    bus.cpu_send = 1'b1;
    bus.cpu_get = both;
    bus.cpu_row = row;
    bus.cpu_wdata = data;
    if (row < 5'd20) model[row] = data;
    @(negedge clk);
    chk("send_we", bus.mem_we, row < 5'd20);
    chk("send_en", bus.mem_en, row < 5'd20);
    if (row < 5'd20) begin
      chk("send_addr", bus.mem_addr, row);
      chk("send_wdata", bus.mem_wdata, data);
    end
    chk("send_stall", bus.cpu_stall, 0);
    chk("send_perr", bus.protocol_err, both);
    cyc();
    bus.cpu_send = 1'b0;
    bus.cpu_get = 1'b0;
    @(negedge clk);
    chk("perr_pulse", bus.protocol_err, 0);
    chk("we_after", bus.mem_we, 0);
    cyc();
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = 32'hA000_0000 | i;
      model[i] = 32'hA000_0000 | i;
    end
    ram[3] = 32'h0000_03FF;
    model[3] = 32'h0000_03FF;
    rst = 1'b0;
    bus.cpu_get = 1'b1;
    bus.cpu_send = 1'b0;
    bus.cpu_row = 5'd3;
    bus.cpu_wdata = 32'h0;
    bus.disp_req = 1'b1;
    bus.disp_row = 5'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", bus.mem_en, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_cvalid", bus.cpu_rvalid, 0);
    chk("rst_dvalid", bus.disp_rvalid, 0);
    chk("rst_perr", bus.protocol_err, 0);
    bus.cpu_get = 1'b0;
    bus.disp_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    get_row(5'd3);
    send_row(5'd19, 32'h0000_0201, 1'b0);
    get_row(5'd19);
    bus.disp_req = 1'b1;
    bus.disp_row = 5'd2;
    bus.cpu_get = 1'b1;
    bus.cpu_row = 5'd5;
    repeat (4) disp_q.push_back(model[2]);
    cpu_q.push_back(model[5]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8 && k % 2 == 0) begin
        chk("cont_disp_en", bus.mem_en, 1);
        chk("cont_disp_addr", bus.mem_addr, 2);
      end
      if (k == 8) chk("cont_cpu_addr", bus.mem_addr, 5);
      chk("cont_stall", bus.cpu_stall, k != 9);
      cyc();
    end
    bus.disp_req = 1'b0;
    bus.cpu_get = 1'b0;
    cyc();
    bus.disp_req = 1'b1;
    bus.disp_row = 5'd10;
    repeat (3) disp_q.push_back(model[10]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("disp_tput_en", bus.mem_en, k % 2 == 0);
      if (k % 2 == 0) chk("disp_tput_addr", bus.mem_addr, 10);
      cyc();
    end
    bus.disp_req = 1'b0;
    cyc();
    get_row(5'd25);
    send_row(5'd20, 32'h1234_5678, 1'b0);
    chk("oor_ram20", ram[20], 32'hA000_0014);
    chk("oor_ram0", ram[0], 32'hA000_0000);
    get_row(5'd0);
    send_row(5'd7, 32'hDEAD_0007, 1'b1);
    get_row(5'd7);
    bus.cpu_get = 1'b1;
    bus.cpu_row = 5'd4;
    cyc();
    rst = 1'b0;
    bus.cpu_get = 1'b0;
    #1;
    chk("mid_rst_cvalid", bus.cpu_rvalid, 0);
    chk("mid_rst_rdata", bus.cpu_rdata, 0);
    chk("mid_rst_stall", bus.cpu_stall, 0);
    chk("mid_rst_en", bus.mem_en, 0);
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    get_row(5'd4);
    repeat (3) cyc();
    chk("cpu_q_empty", 32'(cpu_q.size()), 0);
    chk("disp_q_empty", 32'(disp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
